hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Keeps a small scoreboard of in-flight destination registers (EX, MEM) and detects read-after-write hazards for the instruction in ID.
- Sequences multi-cycle data-memory accesses and generates branch flushes.
- Drives the IF/ID freeze, the ID/EX bubble (control zeroing), the IF/ID flush and the whole-pipeline freeze.

Parameters:
- SB_DEPTH, 2, number of tracked in-flight stages (entry 0 = EX, entry 1 = MEM, …); WB is not tracked because the register file writes before it reads.
- MEM_WAIT, 4, whole-pipeline freeze cycles per data-memory access; 0 = single-cycle memory.
- CNT_W, 3, wait-counter width; must satisfy 2^CNT_W > MEM_WAIT.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fwd_en  in  1  1 = forwarding unit active, 0 = no forwarding
- id_src1  in  4  Rn index of ID instruction
- id_src2  in  4  Rm/Rd index of ID instruction (second read port)
- id_use_src1  in  1  ID instruction reads id_src1
- id_use_src2  in  1  ID instruction reads id_src2
- id_dst  in  4  destination index of ID instruction
- id_wb_en  in  1  ID instruction writes back (already condition-qualified)
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory
- freeze_if  out  1  hold PC and IF/ID register
- bubble_id  out  1  zero ID/EX control fields
- flush_ifid  out  1  clear IF/ID register
- freeze_all  out  1  hold every pipeline register
- mem_ready  out  1  memory access completes this cycle

Behaviour:
- Reset: all outputs 0, scoreboard entries invalid, memory sequencer in IDLE, counter 0. Reset asserted mid-access aborts the access and returns to IDLE immediately.
- Scoreboard entry format: {valid, dst[3:0], is_load}.
  - Updates only when freeze_all = 0. On update, entry0 <= {id_wb_en & ~bubble_id, id_dst, id_mem_read} and entry k <= entry k-1.
  - While freeze_all = 1, all entries hold.
- Hazard match: (id_use_src1 & src1 == entry.dst) | (id_use_src2 & src2 == entry.dst), evaluated on valid entries only.
  - fwd_en = 0: a match on any entry gives hazard.
  - fwd_en = 1: only a match on entry0 with is_load = 1 gives hazard (load-use stall, exactly 1 cycle).
- Memory sequencer, states IDLE, WAIT, DONE:
  - IDLE & mem_req & MEM_WAIT > 0: freeze_all = 1 in that cycle (Mealy), cnt <= MEM_WAIT-1; go to WAIT, or straight to DONE if MEM_WAIT == 1.
  - WAIT: freeze_all = 1, cnt decrements; at cnt == 0, go to DONE.
  - DONE: freeze_all = 0, mem_ready = 1, go to IDLE. mem_req is ignored in DONE because the same instruction is still in MEM.
  - MEM_WAIT == 0: state stays IDLE, mem_ready = mem_req, freeze_all never asserts.
  - Net effect: exactly MEM_WAIT frozen cycles per access. Back-to-back accesses each pay MEM_WAIT.
- Output priority, all combinational from the scoreboard, state and inputs:
  1. freeze_all = 1 → freeze_if = 1, bubble_id = 0, flush_ifid = 0. Hazard and branch are deferred and are re-evaluated once freeze_all drops.
  2. ex_branch_taken → flush_ifid = 1, bubble_id = 1, freeze_if = 0 (PC takes target). Any simultaneous hazard is ignored because the ID instruction is squashed.
  3. hazard → freeze_if = 1, bubble_id = 1.
  4. Otherwise all 0.
- Register 0 is not special; R15 hazards are tracked like any other index.

Decomposition:
- Shared package (arm_pipe_pkg): state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2), scoreboard entry typedef, register-index width constant 4.
- One sub-module: mem_wait_sequencer (FSM + counter; outputs mem_freeze, mem_ready).
- Scoreboard and priority logic stay in the top module.

Test Plan:
- Reset, then `fwd_en = 0`; issue ADD R1 (`id_wb_en = 1`, `dst = 1`), next ID reads `src1 = 1` → `freeze_if` and `bubble_id` high for 2 cycles, then release.
- `fwd_en = 1`; LDR R2 issued, next ID reads `src2 = 2` with `use_src2 = 1` → exactly 1 stall cycle. Same with a non-load producer → 0 stall cycles.
- `MEM_WAIT = 4`; `mem_req` held high → `freeze_all` high 4 cycles, `mem_ready` pulses in the 5th cycle. Scoreboard contents are unchanged across the freeze.
- Hazard and `ex_branch_taken` in the same cycle → `flush_ifid = 1`, `bubble_id = 1`, `freeze_if = 0`. Branch during `freeze_all` → no flush until the freeze ends.
- `rst` pulsed during WAIT (cnt = 2) → all outputs 0 asynchronously; next `mem_req` restarts a full 4-cycle wait.
- `MEM_WAIT = 0` build; `mem_req = 1` → `mem_ready = 1` the same cycle, `freeze_all` never asserts.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline hazard/stall logic.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } sb_entry_t;

  // True when a valid in-flight entry writes a register the ID instruction reads.
  function automatic logic src_match(
    input logic             use1,
    input logic [REG_W-1:0] src1,
    input logic             use2,
    input logic [REG_W-1:0] src2,
    input sb_entry_t        e
  );
    return e.valid & ((use1 & (src1 == e.dst)) | (use2 & (src2 == e.dst)));
  endfunction

endpackage

// File: rtl/mem_wait_sequencer.sv
// Data-memory wait sequencer: freezes the whole pipeline for MEM_WAIT cycles
// per access, then signals completion for one cycle.
module mem_wait_sequencer
  import arm_pipe_pkg::*;
#(
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  output logic mem_freeze_o,
  output logic mem_ready_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The IDLE cycle that sees the request is itself frozen, so WAIT covers the
  // remaining MEM_WAIT-1 cycles and exits as the counter reaches zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_freeze_o = 1'b0;
    mem_ready_o  = 1'b0;
    if (MEM_WAIT == 0) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      mem_ready_o = mem_req_i;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req_i) begin
            mem_freeze_o = 1'b1;
            cnt_d        = CNT_INIT;
            state_d      = (MEM_WAIT == 1) ? ST_DONE : ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          mem_freeze_o = 1'b1;
          cnt_d        = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DONE: begin
          mem_ready_o = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central stall/flush sequencer: in-flight destination scoreboard, RAW hazard
// detection for the ID instruction, memory-wait freeze and branch flush.
module hazard_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int SB_DEPTH = 2,
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  output logic             freeze_if,
  output logic             bubble_id,
  output logic             flush_ifid,
  output logic             freeze_all,
  output logic             mem_ready
);

  sb_entry_t sb_q [SB_DEPTH];
  logic      hazard;
  logic      seq_freeze;
  logic      seq_ready;

  mem_wait_sequencer #(
    .MEM_WAIT (MEM_WAIT),
    .CNT_W    (CNT_W)
  ) u_mem_seq (
    .clk          (clk),
    .rst          (rst),
    .mem_req_i    (mem_req),
    .mem_freeze_o (seq_freeze),
    .mem_ready_o  (seq_ready)
  );

  // With forwarding, only a load still in EX cannot be bypassed in time.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      hazard = hazard |
               (src_match(id_use_src1, id_src1, id_use_src2, id_src2, sb_q[k]) &
                (~fwd_en | ((k == 0) & sb_q[k].is_load)));
    end
  end

  // Output priority: memory freeze, then branch squash, then hazard stall.
  always_comb begin
    freeze_if  = 1'b0;
    bubble_id  = 1'b0;
    flush_ifid = 1'b0;
    freeze_all = 1'b0;
    mem_ready  = 1'b0;
    if (rst) begin
      freeze_all = 1'b0;
    end else if (seq_freeze) begin
      freeze_all = 1'b1;
      freeze_if  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      bubble_id  = 1'b1;
      mem_ready  = seq_ready;
    end else if (hazard) begin
      freeze_if  = 1'b1;
      bubble_id  = 1'b1;
      mem_ready  = seq_ready;
    end else begin
      mem_ready  = seq_ready;
    end
  end

  // Scoreboard shift; a bubbled ID instruction enters as an invalid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else if (!freeze_all) begin
      sb_q[0] <= {id_wb_en & ~bubble_id, id_dst, id_mem_read};
      for (int k = 1; k < SB_DEPTH; k++) begin
        sb_q[k] <= sb_q[k-1];
      end
    end else begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        sb_q[k] <= sb_q[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (MEM_WAIT=4 and 0).
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en;
  logic [3:0] id_src1, id_src2, id_dst;
  logic       id_use_src1, id_use_src2, id_wb_en, id_mem_read;
  logic       ex_branch_taken, mem_req;

  logic freeze_if, bubble_id, flush_ifid, freeze_all, mem_ready;
  logic z_freeze_if, z_bubble_id, z_flush_ifid, z_freeze_all, z_mem_ready;
  logic z_froze = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.SB_DEPTH(2), .MEM_WAIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .freeze_if(freeze_if), .bubble_id(bubble_id), .flush_ifid(flush_ifid),
    .freeze_all(freeze_all), .mem_ready(mem_ready)
  );

  hazard_stall_controller #(.SB_DEPTH(2), .MEM_WAIT(0), .CNT_W(3)) dut_z (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .freeze_if(z_freeze_if), .bubble_id(z_bubble_id), .flush_ifid(z_flush_ifid),
    .freeze_all(z_freeze_all), .mem_ready(z_mem_ready)
  );

  // Sticky record of any freeze from the single-cycle-memory build.
  always @(negedge clk) begin
    if (z_freeze_all) z_froze <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic u1, input logic [3:0] s1, input logic u2,
                        input logic [3:0] s2, input logic wb, input logic [3:0] d,
                        input logic ld);
    id_use_src1 = u1; id_src1 = s1;
    id_use_src2 = u2; id_src2 = s2;
    id_wb_en    = wb; id_dst  = d;
    id_mem_read = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic check_ctl(input string tag, input logic fi, input logic bi, input logic fl);
    check_eq({tag, "_freeze_if"}, {31'd0, freeze_if}, {31'd0, fi});
    check_eq({tag, "_bubble_id"}, {31'd0, bubble_id}, {31'd0, bi});
    check_eq({tag, "_flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fl});
  endtask

  initial begin
    int  frozen;
    logic got_ready;
    rst = 1'b1; fwd_en = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0;
    nop();

    // Reset state
    @(negedge clk);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset_freeze_all", {31'd0, freeze_all}, 32'd0);
    check_eq("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // No forwarding: ADD R1 then a reader of R1 stalls 2 cycles
    fwd_en = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
    @(negedge clk); check_ctl("nofwd_producer", 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
    @(negedge clk); check_ctl("nofwd_stall1", 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk); check_ctl("nofwd_stall2", 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk); check_ctl("nofwd_release", 1'b0, 1'b0, 1'b0);
    tick();
    nop(); tick(); tick();

    // Forwarding: load-use stalls exactly 1 cycle
    fwd_en = 1'b1;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
    @(negedge clk); check_ctl("ldr_issue", 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    @(negedge clk); check_ctl("loaduse_stall", 1'b1, 1'b1, 1'b0);
    tick();
    @(negedge clk); check_ctl("loaduse_release", 1'b0, 1'b0, 1'b0);
    tick();

    // Forwarding: ALU producer causes no stall
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b0);
    tick();
    set_id(1'b0, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
    @(negedge clk); check_ctl("alu_fwd_nostall", 1'b0, 1'b0, 1'b0);
    tick();

    // R15 tracked like any register
    fwd_en = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b0);
    tick();
    set_id(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
    @(negedge clk); check_ctl("r15_stall", 1'b1, 1'b1, 1'b0);
    tick();
    nop(); tick(); tick();

    // Memory wait: 4 frozen cycles, ready in the 5th, scoreboard held
    fwd_en = 1'b1;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, 1'b1);
    tick();
    mem_req = 1'b1;
    set_id(1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("memwait_freeze_all_%0d", i), {31'd0, freeze_all}, 32'd1);
      check_eq($sformatf("memwait_ready_%0d", i), {31'd0, mem_ready}, 32'd0);
      check_ctl($sformatf("memwait_ctl_%0d", i), 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        check_eq("zwait_ready_same_cycle", {31'd0, z_mem_ready}, 32'd1);
        check_eq("zwait_no_freeze", {31'd0, z_freeze_all}, 32'd0);
      end
      tick();
    end
    @(negedge clk);
    check_eq("memdone_freeze_all", {31'd0, freeze_all}, 32'd0);
    check_eq("memdone_ready", {31'd0, mem_ready}, 32'd1);
    check_ctl("memdone_held_loaduse", 1'b1, 1'b1, 1'b0);
    tick();
    mem_req = 1'b0; nop();
    @(negedge clk);
    check_eq("memidle_ready", {31'd0, mem_ready}, 32'd0);
    tick(); tick();

    // Hazard and branch together: branch wins
    fwd_en = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
    tick();
    set_id(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    ex_branch_taken = 1'b1;
    @(negedge clk); check_ctl("branch_over_hazard", 1'b0, 1'b1, 1'b1);
    tick();
    ex_branch_taken = 1'b0; nop(); tick(); tick();

    // Branch during freeze is deferred until freeze ends
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_ctl($sformatf("branch_frozen_%0d", i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    @(negedge clk);
    check_ctl("branch_after_freeze", 1'b0, 1'b1, 1'b1);
    check_eq("branch_after_freeze_fa", {31'd0, freeze_all}, 32'd0);
    tick();
    mem_req = 1'b0; ex_branch_taken = 1'b0; tick();

    // Reset mid-WAIT aborts; next access pays a full wait
    mem_req = 1'b1;
    tick(); tick();
    check_eq("pre_abort_freeze_all", {31'd0, freeze_all}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_freeze_all", {31'd0, freeze_all}, 32'd0);
    check_eq("abort_freeze_if", {31'd0, freeze_if}, 32'd0);
    check_eq("abort_mem_ready", {31'd0, mem_ready}, 32'd0);
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    mem_req = 1'b1;
    frozen = 0; got_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (freeze_all) frozen++;
      if (mem_ready) begin
        got_ready = 1'b1;
        break;
      end
      tick();
    end
    check_eq("restart_frozen_cycles", frozen, 32'd4);
    check_eq("restart_ready_seen", {31'd0, got_ready}, 32'd1);
    tick();
    mem_req = 1'b0; tick();

    check_eq("zwait_never_froze", {31'd0, z_froze}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
